// File: rtl/mdio_frame_engine.sv
// MDIO (clause 22) management frame engine: serialises one read or write
// frame per accepted command, generating mdc and the mdio tristate controls.
module mdio_frame_engine #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned PRE_LEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_read,
    input  logic [4:0]  cmd_phy,
    input  logic [4:0]  cmd_reg,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_ST, S_OP, S_PHY, S_REG, S_TA, S_DATA, S_END
    } state_t;

    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
    localparam logic [4:0] PRE_LOAD = 5'(PRE_LEN - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        mdc_q, mdc_d;
    logic        mdio_o_q, mdio_o_d;
    logic        oe_q, oe_d;
    logic        ready_q, ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        ta_err_q, ta_err_d;
    logic [15:0] shreg_q, shreg_d;
    logic        read_q, read_d;
    logic [4:0]  phy_q, phy_d;
    logic [4:0]  reg_q, reg_d;
    logic [15:0] wdata_q, wdata_d;

    // Pad drive {oe, o} for the bit that starts with counter value c in state s.
    function automatic logic [1:0] drive_bits(state_t s, logic [4:0] c, logic rd,
                                              logic [4:0] p, logic [4:0] r,
                                              logic [15:0] w);
        logic [1:0] b;
        b = 2'b01;
        case (s)
            S_PRE:  b = 2'b11;
            S_ST:   b = {1'b1, (c == 5'd0)};
            S_OP:   b = {1'b1, rd ? c[0] : (c == 5'd0)};
            S_PHY:  b = {1'b1, p[c[2:0]]};
            S_REG:  b = {1'b1, r[c[2:0]]};
            S_TA:   b = rd ? 2'b01 : {1'b1, c[0]};
            S_DATA: b = rd ? 2'b01 : {1'b1, w[c[3:0]]};
            default: b = 2'b01;
        endcase
        return b;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            cnt_q       <= '0;
            mdc_q       <= 1'b0;
            mdio_o_q    <= 1'b1;
            oe_q        <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            ta_err_q    <= 1'b0;
            shreg_q     <= '0;
            read_q      <= 1'b0;
            phy_q       <= '0;
            reg_q       <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            mdc_q       <= mdc_d;
            mdio_o_q    <= mdio_o_d;
            oe_q        <= oe_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            ta_err_q    <= ta_err_d;
            shreg_q     <= shreg_d;
            read_q      <= read_d;
            phy_q       <= phy_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        mdc_d       = mdc_q;
        mdio_o_d    = mdio_o_q;
        oe_d        = oe_q;
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        ta_err_d    = ta_err_q;
        shreg_d     = shreg_q;
        read_d      = read_q;
        phy_d       = phy_q;
        reg_d       = reg_q;
        wdata_d     = wdata_q;

        if (state_q == S_IDLE) begin
            ready_d = 1'b1;
            if (cmd_valid && ready_q) begin
                read_d   = cmd_read;
                phy_d    = cmd_phy;
                reg_d    = cmd_reg;
                wdata_d  = cmd_wdata;
                state_d  = S_PRE;
                cnt_d    = PRE_LOAD;
                div_d    = DIV_LOAD;
                mdc_d    = 1'b0;
                mdio_o_d = 1'b1;
                oe_d     = 1'b1;
                ready_d  = 1'b0;
            end
        end else if (div_q != '0) begin
            div_d = div_q - 8'd1;
        end else begin
            div_d = DIV_LOAD;
            mdc_d = ~mdc_q;
            if (!mdc_q) begin
                // Rising mdc: the PHY's data is sampled here.
                if (read_q && state_q == S_TA && cnt_q == '0)
                    ta_err_d = mdio_i;
                if (read_q && state_q == S_DATA)
                    shreg_d = {shreg_q[14:0], mdio_i};
            end else begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 5'd1;
                end else begin
                    case (state_q)
                        S_PRE:  begin state_d = S_ST;   cnt_d = 5'd1;  end
                        S_ST:   begin state_d = S_OP;   cnt_d = 5'd1;  end
                        S_OP:   begin state_d = S_PHY;  cnt_d = 5'd4;  end
                        S_PHY:  begin state_d = S_REG;  cnt_d = 5'd4;  end
                        S_REG:  begin state_d = S_TA;   cnt_d = 5'd1;  end
                        S_TA:   begin state_d = S_DATA; cnt_d = 5'd15; end
                        S_DATA: begin state_d = S_END;  cnt_d = 5'd0;  end
                        default: begin
                            state_d     = S_IDLE;
                            cnt_d       = '0;
                            div_d       = '0;
                            ready_d     = 1'b1;
                            rsp_valid_d = 1'b1;
                            if (read_q) begin
                                rdata_d = shreg_q;
                                err_d   = ta_err_q;
                            end else begin
                                err_d   = 1'b0;
                            end
                        end
                    endcase
                end
                {oe_d, mdio_o_d} = drive_bits(state_d, cnt_d, read_q, phy_q, reg_q, wdata_q);
            end
        end
    end

    assign cmd_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mdc       = mdc_q;
    assign mdio_o    = mdio_o_q;
    assign mdio_oe   = oe_q;

endmodule

// File: doc/mdio_frame_engine.md
MDIO_FRAME_ENGINE -- requirements
Module: mdio_frame_engine

Interface
REQ-001 Parameter: CLK_DIV, 4, MDC half-period in clk cycles; legal range 1..255.
REQ-002 Parameter: PRE_LEN, 32, preamble length in bits; legal range 1..32.
REQ-003 Port: clk  input  1  single system clock; all logic on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: cmd_valid  input  1  command request from the upstream register sequencer.
REQ-006 Port: cmd_ready  output  1  engine idle; a command is accepted on any clk edge where cmd_valid and cmd_ready are both 1.
REQ-007 Port: cmd_read  input  1  1 selects a read frame, 0 selects a write frame.
REQ-008 Port: cmd_phy  input  5  PHY address.
REQ-009 Port: cmd_reg  input  5  register address.
REQ-010 Port: cmd_wdata  input  16  write data; ignored for reads.
REQ-011 Port: rsp_valid  output  1  one-clk pulse at frame completion, for both reads and writes.
REQ-012 Port: rsp_rdata  output  16  read data; updated only by reads.
REQ-013 Port: rsp_err  output  1  read turnaround error; valid with rsp_valid.
REQ-014 Port: mdc  output  1  management clock to the PHY.
REQ-015 Port: mdio_o  output  1  serial data out, for the external tristate buffer.
REQ-016 Port: mdio_oe  output  1  1 drives mdio_o onto the MDIO pad.
REQ-017 Port: mdio_i  input  1  MDIO pad input; externally pulled up.

Function
REQ-018 States: IDLE, PRE, ST, OP, PHY, REG, TA, DATA, END; cmd_ready is 1 only in IDLE and rst is 0.
REQ-019 Acceptance latches cmd_read, cmd_phy, cmd_reg and cmd_wdata, then moves to PRE; cmd_valid outside IDLE is ignored and latched fields do not change.
REQ-020 Bit period is 2*CLK_DIV clk cycles: mdc low for CLK_DIV cycles, then high for CLK_DIV cycles; the first low phase starts on the clk edge after acceptance.
REQ-021 mdc is held 0 in IDLE.
REQ-022 mdio_o and mdio_oe change only at the start of a low phase.
REQ-023 mdio_i is sampled on the clk edge that raises mdc.
REQ-024 Frame order: PRE_LEN ones; ST = 0,1; OP = 0,1 for write or 1,0 for read; PHY address MSB first; register address MSB first; TA; 16 data bits MSB first; END.
REQ-025 Per-state bit counter: 5 bits, loaded at state entry, decremented per bit; the state advances when the counter reaches 0 at the end of a bit period.
REQ-026 Write frame: mdio_oe is 1 from PRE through DATA; TA drives 1,0; DATA drives the latched wdata.
REQ-027 Read frame: mdio_oe drops to 0 at the start of TA and stays 0 through DATA and END.
REQ-028 Read TA: the second TA bit is sampled; rsp_err is 1 if that sample is 1.
REQ-029 Read DATA: bits are shifted into a 16-bit register, MSB first.
REQ-030 END: one bit period with mdio_oe = 0 and mdc toggling.
REQ-031 At the end of END: rsp_valid pulses, state returns to IDLE, and cmd_ready rises in the same clk cycle as rsp_valid.
REQ-032 Read completion loads rsp_rdata from the shift register.
REQ-033 Write completion leaves rsp_rdata unchanged and forces rsp_err to 0.
REQ-034 With PRE_LEN = 32, rsp_valid is 1 exactly 130*CLK_DIV clk cycles after the acceptance edge.
REQ-035 A new command may be accepted on the clk edge following rsp_valid.
REQ-036 No CLK_DIV value (1..255) produces a glitch or shortened mdc phase.

Reset
REQ-037 While rst is 1, asynchronously: state = IDLE, mdc = 0, mdio_o = 1, mdio_oe = 0, cmd_ready = 0, rsp_valid = 0, rsp_rdata = 0x0000, rsp_err = 0, and all counters = 0.
REQ-038 Reset mid-frame aborts the frame immediately: no rsp_valid is issued for the aborted frame, and cmd_ready = 1 on the first clk edge after rst deasserts.

Verification
REQ-039 Write, CLK_DIV = 2, phy = 0x10, reg = 0x10, wdata = 0x0060 -> bits on mdc rising edges: 32 ones, 01, 01, 10000, 10000, 10, 0000000001100000; mdio_oe = 1 for 64 bits; rsp_valid at cycle 260; rsp_err = 0.
REQ-040 Read, phy = 0x10, reg = 0x00; PHY model drives 0 on TA bit 2, then 0x8140 -> mdio_oe = 0 from TA onward; rsp_rdata = 0x8140; rsp_err = 0.
REQ-041 Read with no PHY response (mdio_i = 1 throughout) -> rsp_rdata = 0xFFFF, rsp_err = 1.
REQ-042 cmd_valid held high with two queued writes -> second command accepted on the edge after the first rsp_valid; a cmd_wdata change mid-frame does not alter the transmitted bits.
REQ-043 rst pulsed during data bit 5 of a write -> mdc = 0 and mdio_oe = 0 immediately; no rsp_valid; cmd_ready = 1 one clk after release; the next write completes normally.
REQ-044 CLK_DIV = 1, back-to-back read then write -> mdc = clk/2 with no shortened phase; per-frame latency 130 cycles.
